decimal_entry: RTL
==================

# decimal_entry

Operator-input front end for the stack CPU: accepts decimal digits one at a time from board switches and buttons, echoes the entered digits for the seven-segment displays, and converts the three-digit BCD entry into the 8-bit binary word that drives the CPU `in` bus. It is the inverse of the output path (binary → BCD → 7-seg). Conversion is sequential (reverse double-dabble, one bit per cycle). Out-of-range or illegal entries raise an error instead of producing a value.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on each button input (≥2).
- `clk  in  1`: system clock.
- `reset  in  1`: one clock; reset is asynchronous and active-low.
- `digit_in  in  4`: BCD digit from switches; sampled on the `digit_btn` edge.
- `digit_btn  in  1`: raw push button; each rising edge enters one digit.
- `enter_btn  in  1`: raw push button; a rising edge starts conversion.
- `clear_btn  in  1`: raw push button; a rising edge aborts entry and clears the digits and error.
- `value  out  8`: last successfully converted binary value; connects to CPU `in`.
- `value_valid  out  1`: one-cycle pulse when `value` updates.
- `busy  out  1`: high while converting.
- `entry_error  out  1`: sticky flag for an illegal digit or overflow.
- `ones`, `tens`, `hundreds  out  4 each`: entered digits, for display echo.

## Operation
- Each button passes through a `SYNC_STAGES` synchronizer, then a rising-edge detector (registered previous level). Each press produces one internal pulse.
- State machine:
  - **ENTRY** (the reset state): accepts digit pulses.
  - **CONVERT**: runs the conversion.
  - **DONE**: lasts one cycle, then returns to ENTRY.
- Digit pulse in ENTRY:
  - If `digit_in` ≤ 9: `hundreds`←`tens`, `tens`←`ones`, `ones`←`digit_in`. A fourth digit pushes the oldest one out (rolling window).
  - If `digit_in` > 9: the digits are unchanged and `entry_error` is set.
- Enter pulse in ENTRY:
  - The overflow check is combinational on the held digits. The entry overflows if its value is > 255, i.e. hundreds > 2, or hundreds = 2 and tens > 5, or 2-5 and ones > 5.
  - On overflow: set `entry_error`, stay in ENTRY, leave `value` unchanged.
  - Otherwise: load the 20-bit shift register {hundreds, tens, ones, 8'b0}, clear the iteration counter, and go to CONVERT.
- Enter pulse with no digits entered: the digits are 000, so `value` = 0 with a valid pulse.
- Each CONVERT cycle:
  - Shift the 20-bit register right by one.
  - Then subtract 3 from each BCD nibble that is ≥ 8.
  - After 8 iterations the low 8 bits hold the binary result. Go to DONE.
- DONE:
  - `value` ← the low 8 bits and `value_valid` pulses.
  - The digits are retained so the display keeps showing the entry.
  - `entry_error` is cleared on a successful conversion.
- Clear pulse, in any state:
  - Go to ENTRY and zero the digits and `entry_error`.
  - Abort any conversion; no valid pulse is produced.
  - `value` is retained.
- Same-cycle event priority is clear > enter > digit. A lower-priority pulse in the same cycle is dropped.
- Digit and enter pulses during CONVERT or DONE are dropped.
- Reset values: `value` = 0, `value_valid` = 0, `busy` = 0, `entry_error` = 0, all digits = 0, state = ENTRY, and the synchronizer and edge registers = 0.
- A reset asserted mid-conversion returns everything to the reset values immediately. No partial `value` is ever output.

## Timing
- Button-to-pulse latency: `SYNC_STAGES` + 1 cycles from the raw rising edge.
- A digit is visible on `ones` one cycle after its internal pulse.
- Enter pulse at cycle E:
  - `busy` = 1 during cycles E+1 … E+8 (8 CONVERT cycles).
  - DONE at cycle E+9: `value` updates and `value_valid` = 1 at E+9 only.
  - `busy` = 0 at E+9.
- Overflow or illegal digit: `entry_error` is set on the cycle after the pulse.
- Clear: `busy` and `entry_error` are 0 on the cycle after the pulse.
- Minimum spacing between successive conversions: 10 cycles.

## Structure
- Shared package holds:
  - state enum `{ENTRY, CONVERT, DONE}`
  - `BCD_W = 4`, `BIN_W = 8`, `CONV_ITER = 8`, `MAX_VALUE = 255`
- One sub-module, `bcd_to_bin_seq`:
  - inputs: start, the three digits
  - outputs: busy, done, an 8-bit result
  - contains the 20-bit shift register and the 3-bit iteration counter
- The top level keeps the synchronizers, edge detectors, digit window, overflow check and error flag.

## Test plan
- Digits 2,5,5 then enter → `busy` for 8 cycles, `value` = 0xFF, one `value_valid` pulse, `entry_error` = 0.
- Digits 1,2,3,4 then enter → display shows 2/3/4, `value` = 0xEA (234).
- After the previous test, digits 2,5,6 then enter → `entry_error` = 1, no valid pulse, `value` stays 0xEA.
- Digit 0xA → digits unchanged, `entry_error` = 1. A later clear → error = 0 and digits = 000.
- Digits 1,0,0, enter, then clear at E+4 → no `value_valid`, `value` unchanged, state returns to ENTRY.
- `reset` low at E+3 of a conversion of 199 → all outputs at their reset values. After release, re-entering 1,9,9 and enter → `value` = 0xC7.

Source files
------------

// File: rtl/decimal_entry_pkg.sv
// decimal_entry_pkg: shared widths, controller states and the entry range check
package decimal_entry_pkg;
   localparam int BCD_W     = 4;
   localparam int BIN_W     = 8;
   localparam int CONV_ITER = 8;
   localparam int MAX_VALUE = 255;
   typedef enum logic [1:0] {ENTRY, CONVERT, DONE} state_e;
   function automatic logic overflow(input logic [BCD_W-1:0] h, input logic [BCD_W-1:0] t,
                                     input logic [BCD_W-1:0] o);
      return (int'(h) * 100 + int'(t) * 10 + int'(o)) > MAX_VALUE;
   endfunction
endpackage

// File: rtl/decimal_entry_bcd_to_bin_seq.sv
// bcd_to_bin_seq: reverse double-dabble, one bit per cycle over a 20-bit {BCD, binary} register
module bcd_to_bin_seq
   import decimal_entry_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [BCD_W-1:0] hundreds_i,
   input  logic [BCD_W-1:0] tens_i,
   input  logic [BCD_W-1:0] ones_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [BIN_W-1:0] result_o
);
   logic [19:0] sr_q, sr_d, shifted;
   logic [2:0]  cnt_q;
   logic        busy_q;
   always_comb begin
      shifted = sr_q >> 1;
      sr_d    = shifted;
      for (int n = 0; n < 3; n++)
         sr_d[8+4*n +: 4] = (shifted[8+4*n +: 4] >= 4'd8) ? shifted[8+4*n +: 4] - 4'd3
                                                          : shifted[8+4*n +: 4];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q   <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (abort_i) begin
         busy_q <= 1'b0;
      end else if (start_i) begin
         sr_q   <= {hundreds_i, tens_i, ones_i, 8'b0};
         cnt_q  <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         sr_q   <= sr_d;
         cnt_q  <= cnt_q + 3'd1;
         busy_q <= cnt_q != 3'(CONV_ITER - 1);
      end
   end
   // done and result are taken from the final iteration's next-state value
   assign busy_o   = busy_q;
   assign done_o   = busy_q && cnt_q == 3'(CONV_ITER - 1);
   assign result_o = sr_d[BIN_W-1:0];
endmodule

// File: rtl/decimal_entry.sv
// decimal_entry: debounced-button decimal entry with a rolling 3-digit window and
// sequential BCD-to-binary conversion feeding the CPU input bus
module decimal_entry
   import decimal_entry_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [BCD_W-1:0] digit_in,
   input  logic             digit_btn,
   input  logic             enter_btn,
   input  logic             clear_btn,
   output logic [BIN_W-1:0] value,
   output logic             value_valid,
   output logic             busy,
   output logic             entry_error,
   output logic [BCD_W-1:0] ones,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] hundreds
);
   logic [2:0][SYNC_STAGES-1:0] sync_q;
   logic [2:0]                  prev_q, level, pulse;
   state_e                      state_q, state_d;
   logic [3*BCD_W-1:0]          digits_q, digits_d;
   logic [BIN_W-1:0]            value_q, value_d, conv_result;
   logic                        err_q, err_d, start, abort, conv_done, conv_busy;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         for (int b = 0; b < 3; b++) begin
            sync_q[b] <= {sync_q[b][SYNC_STAGES-2:0], (b == 0) ? digit_btn : (b == 1) ? enter_btn : clear_btn};
            prev_q[b] <= sync_q[b][SYNC_STAGES-1];
         end
      end
   end
   always_comb begin
      for (int b = 0; b < 3; b++) level[b] = sync_q[b][SYNC_STAGES-1];
      pulse = level & ~prev_q;
   end
   // priority: clear (pulse[2]) > enter (pulse[1]) > digit (pulse[0])
   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      err_d    = err_q;
      value_d  = value_q;
      start    = 1'b0;
      abort    = 1'b0;
      if (pulse[2]) begin
         state_d  = ENTRY;
         digits_d = '0;
         err_d    = 1'b0;
         abort    = 1'b1;
      end else begin
         case (state_q)
            ENTRY: begin
               if (pulse[1]) begin
                  if (overflow(digits_q[11:8], digits_q[7:4], digits_q[3:0])) err_d = 1'b1;
                  else begin
                     start   = 1'b1;
                     state_d = CONVERT;
                  end
               end else if (pulse[0]) begin
                  if (digit_in > 4'd9) err_d = 1'b1;
                  else digits_d = {digits_q[7:0], digit_in};
               end
            end
            CONVERT: begin
               if (conv_done) begin
                  state_d = DONE;
                  value_d = conv_result;
                  err_d   = 1'b0;
               end
            end
            default: state_d = ENTRY;
         endcase
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ENTRY;
         digits_q <= '0;
         err_q    <= 1'b0;
         value_q  <= '0;
      end else begin
         state_q  <= state_d;
         digits_q <= digits_d;
         err_q    <= err_d;
         value_q  <= value_d;
      end
   end
   bcd_to_bin_seq u_conv (
      .clk       (clk),
      .rst_n     (reset),
      .start_i   (start),
      .abort_i   (abort),
      .hundreds_i(digits_q[11:8]),
      .tens_i    (digits_q[7:4]),
      .ones_i    (digits_q[3:0]),
      .busy_o    (conv_busy),
      .done_o    (conv_done),
      .result_o  (conv_result)
   );
   assign value       = value_q;
   assign value_valid = state_q == DONE;
   assign busy        = state_q == CONVERT;
   assign entry_error = err_q;
   assign hundreds    = digits_q[11:8];
   assign tens        = digits_q[7:4];
   assign ones        = digits_q[3:0];
endmodule
